sys_if_axil_master: RTL and testbench
=====================================

// Module: sys_if_axil_master
// PURPOSE
//  AXI4-Lite slave to sys_if initiator bridge. Converts host AXI4-Lite reads/writes into sys_if register
//  accesses (wen/addr/wdata out, rdata in) driving the system register block. One access in flight at a time.
//  Sits between the host AXI interconnect and the system register file, in the sys_if_clk domain.
// PARAMETERS
//  ADDR_W       32         AXI/sys_if address width
//  RD_WAIT_CYC  2          cycles sys_if_addr is held before sys_if_rdata is sampled (min 1)
//  ADDR_LIMIT   32'h60     first illegal byte address (used only with SYS_IF_ADDR_CHECK_EN)
// PORTS
//  sys_if_clk     in   1       clock
//  sys_if_rst     in   1       synchronous reset, active-high
//  s_axil_awaddr  in   ADDR_W  write address;  s_axil_awvalid in 1; s_axil_awready out 1
//  s_axil_wdata   in   32      write data;     s_axil_wstrb in 4; s_axil_wvalid in 1; s_axil_wready out 1
//  s_axil_bresp   out  2       write response; s_axil_bvalid out 1; s_axil_bready in 1
//  s_axil_araddr  in   ADDR_W  read address;   s_axil_arvalid in 1; s_axil_arready out 1
//  s_axil_rdata   out  32      read data;      s_axil_rresp out 2; s_axil_rvalid out 1; s_axil_rready in 1
//  sys_if_wen     out  1       one-cycle write strobe to register block
//  sys_if_addr    out  ADDR_W  register address
//  sys_if_wdata   out  32      register write data
//  sys_if_rdata   in   32      register read data (combinational from addr in the register block)
// BEHAVIOUR
//  Reset: all readys/valids 0, bresp=rresp=0, s_axil_rdata=0, sys_if_wen=0, sys_if_addr=0, sys_if_wdata=0,
//   FSM=IDLE, capture flags clear, rr_last=READ (so write wins first tie). Reset mid-access aborts it, no response.
//  FSM: IDLE, WR_EXEC, WR_RESP, RD_WAIT, RD_RESP.
//  IDLE: awready=!aw_captured, wready=!w_captured; AW and W captured independently, any order/skew.
//   Write ready = both captured (or completing this cycle). Read request = arvalid && no AW/W captured.
//   Tie (write ready and arvalid with nothing captured): round-robin via rr_last; grant opposite of last.
//   Read granted: arready=1 for one cycle, latch araddr -> sys_if_addr, load wait counter, go RD_WAIT.
//   Write ready at cycle N: go WR_EXEC at N+1.
//  WR_EXEC (1 cycle): sys_if_wen=1, sys_if_addr/wdata = captured values; wstrb!=4'hF -> wen stays 0, resp SLVERR.
//   Next: WR_RESP with bvalid=1 at N+2; clear capture flags.
//  WR_RESP: hold bvalid/bresp until bready; no new AW/W/AR accepted; then IDLE.
//  RD_WAIT: sys_if_addr held for RD_WAIT_CYC cycles; on last cycle s_axil_rdata<=sys_if_rdata, rresp=OKAY.
//   rvalid rises RD_WAIT_CYC cycles after the AR handshake cycle +1.
//  RD_RESP: hold rvalid/rdata/rresp until rready; then IDLE.
//  sys_if_addr/wdata hold last value when idle; sys_if_wen high only in WR_EXEC. Never two responses outstanding.
//  Wait counter width $clog2(RD_WAIT_CYC+1); no wrap, reloads each read.
// CONFIGURATION
//  SYS_IF_ADDR_CHECK_EN defined: addr >= ADDR_LIMIT or addr[1:0]!=0 -> no sys_if access (no wen, read skips
//   RD_WAIT: rvalid next cycle, rdata=0), resp SLVERR. Not defined: every address forwarded, resp OKAY
//   (wstrb rule still applies).
// STRUCTURE
//  Package sys_if_axil_pkg: state enum (IDLE..RD_RESP), RESP_OKAY=2'b00, RESP_SLVERR=2'b10, full-strobe const 4'hF.
//  Single flat module, one FSM plus capture registers and wait counter; no sub-module.
// TESTING
//  1 Write 0xA5A50001 to 0x10 (AW,W same cycle) -> wen=1 exactly one cycle, addr 0x10, bvalid 2 cycles later, OKAY;
//    then read 0x10 -> rdata 0xA5A50001, rvalid RD_WAIT_CYC+1 cycles after AR handshake.
//  2 AW at 0x10 issued, W 5 cycles later -> awready low after capture, wen one cycle after W handshake, single bresp.
//  3 Write(0x10) and read(0x14) valid same cycle after reset -> write granted first; repeat -> read granted first.
//  4 bready low 10 cycles -> bvalid/bresp stable, arready/awready stay 0; rready same check for read path.
//  5 wstrb=4'h3 to 0x10 -> bresp SLVERR, wen never asserted, later read of 0x10 returns old value.
//  6 Macro on, ADDR_LIMIT=0x60: read 0x100 -> rresp SLVERR, rdata 0, sys_if_addr unchanged; macro off -> OKAY.
//    Reset asserted during RD_WAIT -> no rvalid, all outputs at reset values next cycle.

Source files
------------

// File: rtl/sys_if_axil_pkg.sv
// Shared state encoding and response/strobe constants for the AXI4-Lite to sys_if bridge.
package sys_if_axil_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_EXEC,
        WR_RESP,
        RD_WAIT,
        RD_RESP
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [3:0] STRB_FULL   = 4'hF;

endpackage

// File: rtl/sys_if_axil_master.sv
// AXI4-Lite slave to sys_if register initiator, one access in flight at a time.
// Optional macro SYS_IF_ADDR_CHECK_EN rejects out-of-range or misaligned addresses with SLVERR.
//
// state   | meaning
// IDLE    | collecting AW/W independently, arbitrating against AR
// WR_EXEC | one-cycle sys_if write strobe (suppressed on partial strobe / bad address)
// WR_RESP | bvalid held until bready
// RD_WAIT | sys_if_addr held while the register block settles
// RD_RESP | rvalid held until rready
module sys_if_axil_master
    import sys_if_axil_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                RD_WAIT_CYC = 2,
    parameter logic [ADDR_W-1:0] ADDR_LIMIT  = ADDR_W'(32'h60)
) (
    input  logic              sys_if_clk,
    input  logic              sys_if_rst,
    input  logic [ADDR_W-1:0] s_axil_awaddr,
    input  logic              s_axil_awvalid,
    output logic              s_axil_awready,
    input  logic [31:0]       s_axil_wdata,
    input  logic [3:0]        s_axil_wstrb,
    input  logic              s_axil_wvalid,
    output logic              s_axil_wready,
    output logic [1:0]        s_axil_bresp,
    output logic              s_axil_bvalid,
    input  logic              s_axil_bready,
    input  logic [ADDR_W-1:0] s_axil_araddr,
    input  logic              s_axil_arvalid,
    output logic              s_axil_arready,
    output logic [31:0]       s_axil_rdata,
    output logic [1:0]        s_axil_rresp,
    output logic              s_axil_rvalid,
    input  logic              s_axil_rready,
    output logic              sys_if_wen,
    output logic [ADDR_W-1:0] sys_if_addr,
    output logic [31:0]       sys_if_wdata,
    input  logic [31:0]       sys_if_rdata
);

    localparam int CNT_W = $clog2(RD_WAIT_CYC + 1);

    state_t            state;
    logic              aw_captured;
    logic              w_captured;
    logic              rr_last_rd;
    logic              wr_err_q;
    logic [ADDR_W-1:0] aw_addr_q;
    logic [31:0]       w_data_q;
    logic [3:0]        w_strb_q;
    logic [CNT_W-1:0]  wait_cnt;

    logic              in_idle;
    logic              wr_ready;
    logic              rd_req;
    logic              tie;
    logic              rd_grant;
    logic              wr_go;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic [3:0]        wr_strb;
    logic              wr_addr_ok;
    logic              rd_addr_ok;

    // Readies are combinational so AW/W can complete in the same cycle the write is launched;
    // gating with reset keeps every ready low while reset is held.
    assign in_idle  = (state == IDLE) && !sys_if_rst;
    assign wr_ready = (aw_captured || s_axil_awvalid) && (w_captured || s_axil_wvalid);
    assign rd_req   = s_axil_arvalid && !aw_captured && !w_captured;
    assign tie      = wr_ready && rd_req;
    assign rd_grant = in_idle && rd_req && (!wr_ready || !rr_last_rd);
    assign wr_go    = in_idle && wr_ready && !rd_grant;

    assign s_axil_awready = in_idle && !aw_captured && !rd_grant;
    assign s_axil_wready  = in_idle && !w_captured && !rd_grant;
    assign s_axil_arready = rd_grant;

    assign wr_addr = aw_captured ? aw_addr_q : s_axil_awaddr;
    assign wr_data = w_captured  ? w_data_q  : s_axil_wdata;
    assign wr_strb = w_captured  ? w_strb_q  : s_axil_wstrb;

`ifdef SYS_IF_ADDR_CHECK_EN
    assign wr_addr_ok = (wr_addr < ADDR_LIMIT) && (wr_addr[1:0] == 2'b00);
    assign rd_addr_ok = (s_axil_araddr < ADDR_LIMIT) && (s_axil_araddr[1:0] == 2'b00);
`else
    assign wr_addr_ok = 1'b1;
    assign rd_addr_ok = 1'b1;
`endif

    always_ff @(posedge sys_if_clk) begin
        if (sys_if_rst) begin
            state         <= IDLE;
            aw_captured   <= 1'b0;
            w_captured    <= 1'b0;
            rr_last_rd    <= 1'b1;
            wr_err_q      <= 1'b0;
            aw_addr_q     <= '0;
            w_data_q      <= '0;
            w_strb_q      <= '0;
            wait_cnt      <= '0;
            s_axil_bresp  <= RESP_OKAY;
            s_axil_bvalid <= 1'b0;
            s_axil_rdata  <= '0;
            s_axil_rresp  <= RESP_OKAY;
            s_axil_rvalid <= 1'b0;
            sys_if_wen    <= 1'b0;
            sys_if_addr   <= '0;
            sys_if_wdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (s_axil_awvalid && s_axil_awready) begin
                        aw_captured <= 1'b1;
                        aw_addr_q   <= s_axil_awaddr;
                    end
                    if (s_axil_wvalid && s_axil_wready) begin
                        w_captured <= 1'b1;
                        w_data_q   <= s_axil_wdata;
                        w_strb_q   <= s_axil_wstrb;
                    end
                    // Round-robin memory only moves on a genuine tie.
                    if (tie) begin
                        rr_last_rd <= rd_grant;
                    end
                    if (rd_grant) begin
                        if (rd_addr_ok) begin
                            sys_if_addr <= s_axil_araddr;
                            wait_cnt    <= CNT_W'(RD_WAIT_CYC);
                            state       <= RD_WAIT;
                        end else begin
                            s_axil_rdata  <= '0;
                            s_axil_rresp  <= RESP_SLVERR;
                            s_axil_rvalid <= 1'b1;
                            state         <= RD_RESP;
                        end
                    end else if (wr_go) begin
                        sys_if_wen <= wr_addr_ok && (wr_strb == STRB_FULL);
                        wr_err_q   <= !(wr_addr_ok && (wr_strb == STRB_FULL));
                        if (wr_addr_ok) begin
                            sys_if_addr  <= wr_addr;
                            sys_if_wdata <= wr_data;
                        end
                        state <= WR_EXEC;
                    end
                end
                WR_EXEC: begin
                    sys_if_wen    <= 1'b0;
                    s_axil_bvalid <= 1'b1;
                    s_axil_bresp  <= wr_err_q ? RESP_SLVERR : RESP_OKAY;
                    aw_captured   <= 1'b0;
                    w_captured    <= 1'b0;
                    state         <= WR_RESP;
                end
                WR_RESP: begin
                    if (s_axil_bready) begin
                        s_axil_bvalid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                RD_WAIT: begin
                    if (wait_cnt == CNT_W'(1)) begin
                        s_axil_rdata  <= sys_if_rdata;
                        s_axil_rresp  <= RESP_OKAY;
                        s_axil_rvalid <= 1'b1;
                        state         <= RD_RESP;
                    end else begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                end
                RD_RESP: begin
                    if (s_axil_rready) begin
                        s_axil_rvalid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sys_if_axil_master.sv
// Directed bench for sys_if_axil_master with a small register-block model on the sys_if side.
// Expectations follow SYS_IF_ADDR_CHECK_EN when defined for the build.
module tb_sys_if_axil_master;

    localparam int RDW = 2;
    localparam logic [1:0] OK  = 2'b00;
    localparam logic [1:0] ERR = 2'b10;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] awaddr, wdata, araddr;
    logic [3:0]  wstrb;
    logic        awvalid, wvalid, arvalid, bready, rready;
    logic        awready, wready, arready, bvalid, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic        sys_if_wen;
    logic [31:0] sys_if_addr, sys_if_wdata, sys_if_rdata;

    logic [31:0] regs [16];
    int          wen_cnt = 0;
    logic [31:0] wen_addr_last = '0;
    int          checks = 0;
    int          failures = 0;

    sys_if_axil_master #(.ADDR_W(32), .RD_WAIT_CYC(RDW), .ADDR_LIMIT(32'h60)) dut (
        .sys_if_clk(clk), .sys_if_rst(rst),
        .s_axil_awaddr(awaddr), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
        .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
        .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
        .s_axil_araddr(araddr), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
        .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
        .sys_if_wen(sys_if_wen), .sys_if_addr(sys_if_addr), .sys_if_wdata(sys_if_wdata),
        .sys_if_rdata(sys_if_rdata)
    );

    always #5 clk = ~clk;

    // Register block: 16 words below 0x40, a recognisable pattern above.
    always_comb begin
        sys_if_rdata = 32'hBAD0_0000 ^ sys_if_addr;
        if (sys_if_addr < 32'h40) sys_if_rdata = regs[sys_if_addr[5:2]];
    end

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) regs[i] <= '0;
        end else if (sys_if_wen) begin
            regs[sys_if_addr[5:2]] <= sys_if_wdata;
            wen_cnt       <= wen_cnt + 1;
            wen_addr_last <= sys_if_addr;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic hs_step(output bit ah, output bit wh, output bit rh);
        @(negedge clk);
        ah = awvalid && awready;
        wh = wvalid && wready;
        rh = arvalid && arready;
        @(posedge clk); #1;
        if (ah) awvalid = 1'b0;
        if (wh) wvalid = 1'b0;
        if (rh) arvalid = 1'b0;
    endtask

    task automatic wait_b(output logic [1:0] resp, output int lat);
        lat = 1;
        while (!bvalid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!bvalid) chk("bvalid_timeout", 0, 1);
        resp = bresp;
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic wait_r(output logic [31:0] data, output logic [1:0] resp, output int lat);
        lat = 1;
        while (!rvalid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!rvalid) chk("rvalid_timeout", 0, 1);
        data = rdata;
        resp = rresp;
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp, output int lat);
        bit ah, wh, rh;
        int n = 0;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1;
        while ((awvalid || wvalid) && n < 40) begin
            hs_step(ah, wh, rh);
            n++;
        end
        if (awvalid || wvalid) chk("write_handshake_timeout", 0, 1);
        wait_b(resp, lat);
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] data,
                            output logic [1:0] resp, output int lat);
        bit ah, wh, rh;
        int n = 0;
        araddr = a;
        arvalid = 1'b1;
        while (arvalid && n < 40) begin
            hs_step(ah, wh, rh);
            n++;
        end
        if (arvalid) chk("read_handshake_timeout", 0, 1);
        wait_r(data, resp, lat);
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
        int          exp_wen;
        int          exp_lat;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vec [10];

    initial begin
        logic [1:0]  resp;
        logic [31:0] data;
        int          lat, w0, n;
        bit          ah, wh, rh, ok_a, ok_b;

        vec[0] = '{1'b1, 32'h10, 32'hA5A5_0001, 4'hF, OK,  32'h0,         1, 2,       32'h0};
        vec[1] = '{1'b0, 32'h10, 32'h0,         4'h0, OK,  32'hA5A5_0001, 0, RDW + 1, 32'h10};
        vec[2] = '{1'b1, 32'h14, 32'h1234_5678, 4'hF, OK,  32'h0,         1, 2,       32'h0};
        vec[3] = '{1'b0, 32'h14, 32'h0,         4'h0, OK,  32'h1234_5678, 0, RDW + 1, 32'h14};
        vec[4] = '{1'b1, 32'h10, 32'hDEAD_BEEF, 4'h3, ERR, 32'h0,         0, 2,       32'h0};
        vec[5] = '{1'b0, 32'h10, 32'h0,         4'h0, OK,  32'hA5A5_0001, 0, RDW + 1, 32'h10};
        vec[6] = '{1'b1, 32'h3C, 32'hFFFF_0000, 4'hF, OK,  32'h0,         1, 2,       32'h0};
        vec[7] = '{1'b0, 32'h3C, 32'h0,         4'h0, OK,  32'hFFFF_0000, 0, RDW + 1, 32'h3C};
`ifdef SYS_IF_ADDR_CHECK_EN
        vec[8] = '{1'b0, 32'h100, 32'h0,        4'h0, ERR, 32'h0,         0, 1,       32'h3C};
        vec[9] = '{1'b0, 32'h12,  32'h0,        4'h0, ERR, 32'h0,         0, 1,       32'h3C};
`else
        vec[8] = '{1'b0, 32'h100, 32'h0,        4'h0, OK,  32'hBAD0_0100, 0, RDW + 1, 32'h100};
        vec[9] = '{1'b0, 32'h12,  32'h0,        4'h0, OK,  32'hA5A5_0001, 0, RDW + 1, 32'h12};
`endif

        rst = 1'b1;
        awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b0; rready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_handshake_outputs", {awready, wready, arready, bvalid, rvalid, bresp, rresp, sys_if_wen}, '0);
        chk("reset_sys_if_addr", sys_if_addr, 32'h0);
        chk("reset_sys_if_wdata", sys_if_wdata, 32'h0);
        chk("reset_rdata", rdata, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            w0 = wen_cnt;
            if (vec[i].wr) begin
                axi_write(vec[i].addr, vec[i].data, vec[i].strb, resp, lat);
                chk($sformatf("v%0d_bresp", i), resp, vec[i].exp_resp);
                chk($sformatf("v%0d_bvalid_latency", i), lat, vec[i].exp_lat);
                chk($sformatf("v%0d_wen_pulses", i), wen_cnt - w0, vec[i].exp_wen);
                if (vec[i].exp_wen == 1) chk($sformatf("v%0d_wen_addr", i), wen_addr_last, vec[i].addr);
            end else begin
                axi_read(vec[i].addr, data, resp, lat);
                chk($sformatf("v%0d_rresp", i), resp, vec[i].exp_resp);
                chk($sformatf("v%0d_rdata", i), data, vec[i].exp_rdata);
                chk($sformatf("v%0d_rvalid_latency", i), lat, vec[i].exp_lat);
                chk($sformatf("v%0d_sys_if_addr", i), sys_if_addr, vec[i].exp_addr);
                chk($sformatf("v%0d_no_wen", i), wen_cnt - w0, 0);
            end
        end

        // AW first, W five cycles later.
        w0 = wen_cnt;
        awaddr = 32'h18; awvalid = 1'b1;
        hs_step(ah, wh, rh);
        chk("skew_aw_accepted", ah, 1'b1);
        ok_a = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (awready !== 1'b0 || sys_if_wen !== 1'b0) ok_a = 1'b0;
            @(posedge clk); #1;
        end
        chk("skew_awready_low_no_wen", ok_a, 1'b1);
        wdata = 32'h55AA_55AA; wstrb = 4'hF; wvalid = 1'b1;
        n = 0;
        while (wvalid && n < 40) begin
            hs_step(ah, wh, rh);
            n++;
        end
        chk("skew_wen_after_w", {sys_if_wen, sys_if_addr, sys_if_wdata}, {1'b1, 32'h18, 32'h55AA_55AA});
        wait_b(resp, lat);
        chk("skew_bresp", resp, OK);
        chk("skew_wen_pulses", wen_cnt - w0, 1);
        ok_a = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (bvalid !== 1'b0) ok_a = 1'b0;
        end
        @(posedge clk); #1;
        chk("skew_single_bresp", ok_a, 1'b1);

        // Tie arbitration from reset: write first, then read first.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        awaddr = 32'h10; wdata = 32'h1111_0000; wstrb = 4'hF; araddr = 32'h14;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        hs_step(ah, wh, rh);
        chk("tie1_write_granted", {ah, wh, rh}, 3'b110);
        wait_b(resp, lat);
        n = 0;
        rh = 1'b0;
        while (!rh && n < 40) begin
            hs_step(ah, wh, rh);
            n++;
        end
        wait_r(data, resp, lat);
        chk("tie1_read_after_write", {resp, data}, {OK, 32'h0});
        awaddr = 32'h14; wdata = 32'h2222_0000; araddr = 32'h10;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        hs_step(ah, wh, rh);
        chk("tie2_read_granted", {ah, wh, rh}, 3'b001);
        wait_r(data, resp, lat);
        chk("tie2_read_data", {resp, data}, {OK, 32'h1111_0000});
        n = 0;
        while ((awvalid || wvalid) && n < 40) begin
            hs_step(ah, wh, rh);
            n++;
        end
        wait_b(resp, lat);
        chk("tie2_write_resp", resp, OK);
        axi_read(32'h14, data, resp, lat);
        chk("tie2_write_landed", data, 32'h2222_0000);

        // bready held low: response stable, nothing new accepted.
        awaddr = 32'h20; wdata = 32'h0C0F_FEE0; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        while ((awvalid || wvalid) && n < 40) begin
            hs_step(ah, wh, rh);
            n++;
        end
        n = 0;
        while (!bvalid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        awaddr = 32'h24; araddr = 32'h24;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        ok_a = 1'b1; ok_b = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (bvalid !== 1'b1 || bresp !== OK) ok_a = 1'b0;
            if (awready || wready || arready) ok_b = 1'b0;
            @(posedge clk); #1;
        end
        chk("bhold_stable", ok_a, 1'b1);
        chk("bhold_blocked", ok_b, 1'b1);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        chk("bhold_released", bvalid, 1'b0);

        araddr = 32'h20; arvalid = 1'b1;
        n = 0;
        while (arvalid && n < 40) begin
            hs_step(ah, wh, rh);
            n++;
        end
        n = 0;
        while (!rvalid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        ok_a = 1'b1; ok_b = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (rvalid !== 1'b1 || rresp !== OK || rdata !== 32'h0C0F_FEE0) ok_a = 1'b0;
            if (awready || wready || arready) ok_b = 1'b0;
            @(posedge clk); #1;
        end
        chk("rhold_stable", ok_a, 1'b1);
        chk("rhold_blocked", ok_b, 1'b1);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        chk("rhold_released", rvalid, 1'b0);

        // Reset during RD_WAIT aborts the read.
        araddr = 32'h20; arvalid = 1'b1;
        n = 0;
        while (arvalid && n < 40) begin
            hs_step(ah, wh, rh);
            n++;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_handshake_outputs", {awready, wready, arready, bvalid, rvalid, bresp, rresp, sys_if_wen}, '0);
        chk("midrst_addr_rdata", {sys_if_addr, rdata}, 64'h0);
        rst = 1'b0;
        ok_a = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (rvalid !== 1'b0) ok_a = 1'b0;
        end
        chk("midrst_no_rvalid", ok_a, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
